seq_detector: RTL and testbench



---
 rtl/seq_detect_pkg.sv | 80 ++++++++
 rtl/seq_detect_fsm.sv | 38 +++
 rtl/seq_detector.sv | 34 +++
 tb/tb_seq_detector.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared constants and elaboration-time helpers for the serial pattern detector.
// The KMP failure rule is evaluated here once per parameter set; no runtime tables.
package seq_detect_pkg;

  localparam int MAX_LEN     = 16;
  localparam int STATE_W_MAX = 5;

  localparam int                     DEF_SEQ_LEN = 5;
  localparam logic [DEF_SEQ_LEN-1:0] DEF_SEQ     = 5'b10010;
  localparam bit                     DEF_OVERLAP = 1'b1;

  // Next-state table indexed by the current state, one entry per state S0..S<MAX_LEN>.
  typedef logic [MAX_LEN:0][STATE_W_MAX-1:0] trans_t;

  // Pattern bit i counted from the first bit on the line.
  function automatic logic pat_bit(input logic [MAX_LEN-1:0] seq, input int len, input int i);
    logic [MAX_LEN-1:0] t;
    t = seq >> (len - 1 - i);
    return t[0];
  endfunction

  // Longest proper prefix of the pattern that is also a suffix of its first k bits.
  function automatic int seq_fail(input logic [MAX_LEN-1:0] seq, input int len, input int k);
    int res;
    bit found;
    bit ok;
    res   = 0;
    found = 1'b0;
    for (int j = k - 1; j > 0; j--) begin
      if (!found) begin
        ok = 1'b1;
        for (int t = 0; t < j; t++) begin
          if (pat_bit(seq, len, t) != pat_bit(seq, len, k - j + t)) ok = 1'b0;
        end
        if (ok) begin
          res   = j;
          found = 1'b1;
        end
      end
    end
    return res;
  endfunction

  // Successor of state k on input bit b; the match state first folds back to its restart point.
  function automatic int seq_step(input logic [MAX_LEN-1:0] seq, input int len,
                                  input bit overlap, input int k, input logic b);
    int  j;
    int  res;
    bit  done;
    if (k >= len) j = overlap ? seq_fail(seq, len, len) : 0;
    else          j = k;
    res  = 0;
    done = 1'b0;
    for (int it = 0; it <= MAX_LEN; it++) begin
      if (!done) begin
        if (pat_bit(seq, len, j) == b) begin
          res  = j + 1;
          done = 1'b1;
        end else if (j == 0) begin
          res  = 0;
          done = 1'b1;
        end else begin
          j = seq_fail(seq, len, j);
        end
      end
    end
    return res;
  endfunction

  function automatic trans_t seq_table(input logic [MAX_LEN-1:0] seq, input int len,
                                       input bit overlap, input logic b);
    trans_t t;
    t = '0;
    for (int k = 0; k <= MAX_LEN; k++) begin
      if (k <= len) t[k] = STATE_W_MAX'(seq_step(seq, len, overlap, k, b));
    end
    return t;
  endfunction

endpackage

// File: rtl/seq_detect_fsm.sv
// Moore FSM for the pattern detector: binary state Sk = longest matched prefix length.
// State is exposed so the match decode and any checker can observe it directly.
module seq_detect_fsm
  import seq_detect_pkg::*;
#(
  parameter int                 SEQ_LEN = DEF_SEQ_LEN,
  parameter logic [SEQ_LEN-1:0] SEQ     = DEF_SEQ,
  parameter bit                 OVERLAP = DEF_OVERLAP,
  parameter int                 STATE_W = $clog2(SEQ_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din,
  output logic [STATE_W-1:0] state
);

  localparam trans_t NEXT_0 = seq_table(MAX_LEN'(SEQ), SEQ_LEN, OVERLAP, 1'b0);
  localparam trans_t NEXT_1 = seq_table(MAX_LEN'(SEQ), SEQ_LEN, OVERLAP, 1'b1);

  logic [STATE_W-1:0]     state_next;
  logic [STATE_W_MAX-1:0] idx;

  always_ff @(posedge clk) begin
    if (rst) state <= '0;
    else     state <= state_next;
  end

  // Encodings above S<SEQ_LEN> are unreachable; they recover to S0.
  always_comb begin
    state_next = '0;
    idx        = STATE_W_MAX'(state);
    if (state <= STATE_W'(SEQ_LEN)) begin
      if (din) state_next = STATE_W'(NEXT_1[idx]);
      else     state_next = STATE_W'(NEXT_0[idx]);
    end
  end

endmodule

// File: rtl/seq_detector.sv
// Serial bit-sequence detector: one-cycle flag whenever the latest bits match SEQ.
// flag decodes the registered match state only, so there is no path from din.
module seq_detector
  import seq_detect_pkg::*;
#(
  parameter int                 SEQ_LEN = DEF_SEQ_LEN,
  parameter logic [SEQ_LEN-1:0] SEQ     = DEF_SEQ,
  parameter bit                 OVERLAP = DEF_OVERLAP
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic flag
);

  localparam int STATE_W = $clog2(SEQ_LEN + 1);

  logic [STATE_W-1:0] fsm_state;

  seq_detect_fsm #(
    .SEQ_LEN (SEQ_LEN),
    .SEQ     (SEQ),
    .OVERLAP (OVERLAP),
    .STATE_W (STATE_W)
  ) u_fsm (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .state (fsm_state)
  );

  assign flag = (fsm_state == STATE_W'(SEQ_LEN));

endmodule

// File: tb/tb_seq_detector.sv
// Directed bench for seq_detector: default pattern with and without overlap,
// plus a short all-ones pattern for back-to-back matches.
module tb_seq_detector;

  logic clk;
  logic rst;
  logic din;
  logic flag_a;
  logic flag_b;
  logic flag_c;

  int checks = 0;
  int errors = 0;

  seq_detector dut_a (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .flag (flag_a)
  );

  seq_detector #(.SEQ_LEN(5), .SEQ(5'b10010), .OVERLAP(1'b0)) dut_b (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .flag (flag_b)
  );

  seq_detector #(.SEQ_LEN(3), .SEQ(3'b111), .OVERLAP(1'b1)) dut_c (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .flag (flag_c)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: apply one bit, let the edge sample it, settle before observing
  task automatic step(input logic b);
    din = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    din = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] p;
    p   = 5'b10010;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = i[0];
      @(posedge clk);
      #1;
      checks++;
      if ({flag_a, flag_b, flag_c} !== 3'b000) begin
        errors++;
        $display("FAIL reset_flags edge=%0d got=%b exp=000", i, {flag_a, flag_b, flag_c});
      end
      checks++;
      if (dut_a.fsm_state !== 3'd0) begin
        errors++;
        $display("FAIL reset_state edge=%0d got=%0d exp=0", i, dut_a.fsm_state);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(p[4-i]);
      checks++;
      if (flag_a !== (i == 4)) begin
        errors++;
        $display("FAIL reset_first_match bit=%0d got=%b exp=%b", i, flag_a, (i == 4));
      end
    end
    step(1'b0);
    checks++;
    if (flag_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulse_end got=%b exp=0", flag_a);
    end
  endtask

  task automatic test_stream();
    logic [30:0] s;
    logic        exp_a;
    logic        exp_b;
    int          n_a;
    int          n_b;
    s   = 31'b1100011001000110101001001010001;
    n_a = 0;
    n_b = 0;
    do_reset();
    for (int i = 0; i < 31; i++) begin
      step(s[30-i]);
      exp_a = (i == 10) || (i == 22) || (i == 25);
      exp_b = (i == 10) || (i == 22);
      if (flag_a === 1'b1) n_a++;
      if (flag_b === 1'b1) n_b++;
      checks++;
      if (flag_a !== exp_a) begin
        errors++;
        $display("FAIL stream_overlap bit=%0d got=%b exp=%b", i, flag_a, exp_a);
      end
      checks++;
      if (flag_b !== exp_b) begin
        errors++;
        $display("FAIL stream_no_overlap bit=%0d got=%b exp=%b", i, flag_b, exp_b);
      end
    end
    checks++;
    if (n_a != 3) begin
      errors++;
      $display("FAIL stream_overlap_count got=%0d exp=3", n_a);
    end
    checks++;
    if (n_b != 2) begin
      errors++;
      $display("FAIL stream_no_overlap_count got=%0d exp=2", n_b);
    end
  endtask

  task automatic test_overlap_chain();
    logic [10:0] v;
    logic        exp;
    v = 11'b10010010000;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      step(v[10-i]);
      exp = (i == 4) || (i == 7);
      checks++;
      if (flag_a !== exp) begin
        errors++;
        $display("FAIL overlap_chain bit=%0d got=%b exp=%b", i, flag_a, exp);
      end
    end
  endtask

  task automatic test_reset_mid_match();
    logic [3:0] pre;
    logic [4:0] p;
    pre = 4'b1001;
    p   = 5'b10010;
    do_reset();
    for (int i = 0; i < 4; i++) step(pre[3-i]);
    rst = 1'b1;
    step(1'b0);
    rst = 1'b0;
    checks++;
    if (flag_a !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_during got=%b exp=0", flag_a);
    end
    step(1'b0);
    checks++;
    if (flag_a !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_after got=%b exp=0", flag_a);
    end
    for (int i = 0; i < 5; i++) begin
      step(p[4-i]);
      checks++;
      if (flag_a !== (i == 4)) begin
        errors++;
        $display("FAIL mid_reset_rematch bit=%0d got=%b exp=%b", i, flag_a, (i == 4));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic exp;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1);
      exp = (i >= 2);
      checks++;
      if (flag_c !== exp) begin
        errors++;
        $display("FAIL ones_b2b bit=%0d got=%b exp=%b", i, flag_c, exp);
      end
    end
    step(1'b0);
    checks++;
    if (flag_c !== 1'b0) begin
      errors++;
      $display("FAIL ones_b2b_end got=%b exp=0", flag_c);
    end
  endtask

  initial begin
    rst = 1'b1;
    din = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_overlap_chain();
    test_reset_mid_match();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
